// File: rtl/csr_walk_pkg.sv
`default_nettype none
// ============================================================================
// Package  : csr_walk_pkg
// Brief    : Shared types, target table and pattern helper for the CSR
//            scratchpad walker.
// Revision : 1.0 - initial release
// ============================================================================
package csr_walk_pkg;

    localparam int          NUM_TARGETS_DEF = 5;
    localparam int          TBL_IDX_W       = $clog2(NUM_TARGETS_DEF);
    localparam logic [63:0] PATTERN_DEF     = 64'hA5A5_5A5A_0F0F_F0F0;

    typedef struct packed {
        logic [63:0] addr;
        logic [2:0]  pf;
        logic [10:0] vf;
        logic        vf_active;
    } csr_target_t;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_WR0   = 4'd1,
        ST_RD0   = 4'd2,
        ST_WAIT0 = 4'd3,
        ST_WR1   = 4'd4,
        ST_RD1   = 4'd5,
        ST_WAIT1 = 4'd6,
        ST_NEXT  = 4'd7,
        ST_FIN   = 4'd8
    } walk_state_e;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_DATA    = 2'd1,
        FC_TIMEOUT = 2'd2,
        FC_TAG     = 2'd3
    } fail_code_e;

    // Scratchpad registers: FME, PCIe, VirtIO, HE-LB, PF1 stub. All PF-routed.
    localparam csr_target_t TARGETS [NUM_TARGETS_DEF] = '{
        '{addr: 64'h0000_0000_0000_0028, pf: 3'd0, vf: 11'd0, vf_active: 1'b0},
        '{addr: 64'h0000_0000_0001_0008, pf: 3'd0, vf: 11'd0, vf_active: 1'b0},
        '{addr: 64'h0000_0000_0002_0018, pf: 3'd3, vf: 11'd0, vf_active: 1'b0},
        '{addr: 64'h0000_0000_0000_0100, pf: 3'd2, vf: 11'd0, vf_active: 1'b0},
        '{addr: 64'h0000_0000_0000_0018, pf: 3'd1, vf: 11'd0, vf_active: 1'b0}
    };

    // Out-of-range indices resolve to an all-zero target rather than X.
    function automatic csr_target_t target_at(input logic [7:0] idx);
        if (idx < 8'(NUM_TARGETS_DEF)) begin
            return TARGETS[idx[TBL_IDX_W-1:0]];
        end
        return '0;
    endfunction

    // Base pattern for entry idx; the inverted phase uses its complement.
    function automatic logic [63:0] entry_pattern(input logic [63:0] base,
                                                  input logic [7:0]  idx);
        return base + {56'd0, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_walk_rsp_checker.sv
`default_nettype none
// ============================================================================
// Module   : csr_walk_rsp_checker
// Brief    : Read-completion checker for the CSR walker: timeout counter,
//            tag match, data compare and first-error capture.
// Revision : 1.0 - initial release
// ============================================================================
module csr_walk_rsp_checker
    import csr_walk_pkg::*;
#(
    parameter int TAG_W          = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIDX_W         = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_arm,
    input  logic [TAG_W-1:0]  i_arm_tag,
    input  logic [63:0]       i_arm_data,
    input  logic [TIDX_W-1:0] i_arm_idx,
    input  logic              i_waiting,
    input  logic              i_rsp_valid,
    input  logic [TAG_W-1:0]  i_rsp_tag,
    input  logic [63:0]       i_rsp_data,
    output logic              o_resolved,
    output logic              o_error,
    output logic [TIDX_W:0]   o_err_count,
    output logic [TIDX_W-1:0] o_fail_idx,
    output logic [1:0]        o_fail_code,
    output logic [63:0]       o_fail_rdata
);

    localparam int               CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIDX_W:0]  C_ERR_MAX  = '1;

    logic [CNT_W-1:0]  r_cnt;
    logic [TAG_W-1:0]  r_exp_tag;
    logic [63:0]       r_exp_data;
    logic [TIDX_W-1:0] r_idx;
    logic [TIDX_W:0]   r_err_count;
    logic [TIDX_W-1:0] r_fail_idx;
    fail_code_e        r_fail_code;
    logic [63:0]       r_fail_rdata;

    logic              w_hit;
    logic              w_timeout;
    fail_code_e        w_code;

    // Classify the current wait cycle; a wrong tag outranks a data compare.
    always_comb begin
        w_hit     = i_waiting & i_rsp_valid;
        w_timeout = i_waiting & ~i_rsp_valid & (r_cnt == C_CNT_LAST);
        w_code    = FC_NONE;
        if (w_hit && (i_rsp_tag != r_exp_tag)) begin
            w_code = FC_TAG;
        end else if (w_hit && (i_rsp_data != r_exp_data)) begin
            w_code = FC_DATA;
        end else if (w_timeout) begin
            w_code = FC_TIMEOUT;
        end
    end

    assign o_resolved = w_hit | w_timeout;
    assign o_error    = (w_code != FC_NONE);

    // Latch the outstanding read's tag, expected data and index; run the timer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_exp_tag  <= '0;
            r_exp_data <= '0;
            r_idx      <= '0;
        end else if (i_arm) begin
            r_cnt      <= '0;
            r_exp_tag  <= i_arm_tag;
            r_exp_data <= i_arm_data;
            r_idx      <= i_arm_idx;
        end else if (i_waiting && !i_rsp_valid && (r_cnt != C_CNT_LAST)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Saturating error count; only the first error of a walk is captured.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_err_count  <= '0;
            r_fail_idx   <= '0;
            r_fail_code  <= FC_NONE;
            r_fail_rdata <= '0;
        end else if (o_error) begin
            if (r_err_count != C_ERR_MAX) begin
                r_err_count <= r_err_count + (TIDX_W+1)'(1);
            end
            if (r_err_count == '0) begin
                r_fail_idx   <= r_idx;
                r_fail_code  <= w_code;
                r_fail_rdata <= (w_code == FC_TIMEOUT) ? 64'd0 : i_rsp_data;
            end
        end
    end

    assign o_err_count  = r_err_count;
    assign o_fail_idx   = r_fail_idx;
    assign o_fail_code  = r_fail_code;
    assign o_fail_rdata = r_fail_rdata;

endmodule
`default_nettype wire

// File: rtl/csr_scratch_walker.sv
`default_nettype none
// ============================================================================
// Module   : csr_scratch_walker
// Brief    : CSR self-test engine. Walks the scratchpad table, writing and
//            reading back a pattern and its inverse through the MMIO port.
// Revision : 1.0 - initial release
// ============================================================================
module csr_scratch_walker
    import csr_walk_pkg::*;
#(
    parameter int          NUM_TARGETS    = NUM_TARGETS_DEF,
    parameter logic [63:0] PATTERN        = PATTERN_DEF,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter int          TAG_W          = 8,
    localparam int         TIDX_W         = $clog2(NUM_TARGETS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop_on_fail,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_write,
    output logic [63:0]       req_addr,
    output logic [2:0]        req_pf,
    output logic [10:0]       req_vf,
    output logic              req_vf_active,
    output logic [63:0]       req_wdata,
    output logic [TAG_W-1:0]  req_tag,
    input  logic              rsp_valid,
    input  logic [TAG_W-1:0]  rsp_tag,
    input  logic [63:0]       rsp_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [TIDX_W:0]   err_count,
    output logic [TIDX_W-1:0] fail_idx,
    output logic [1:0]        fail_code,
    output logic [63:0]       fail_rdata
);

    localparam logic [TIDX_W-1:0] C_IDX_LAST = TIDX_W'(NUM_TARGETS - 1);

    walk_state_e       r_state;
    walk_state_e       w_state_nxt;
    logic [TIDX_W-1:0] r_idx;
    logic              r_stop_on_fail;
    logic [TAG_W-1:0]  r_tag;
    logic              r_pass;

    logic              r_req_valid;
    logic              r_req_write;
    logic [63:0]       r_req_addr;
    logic [2:0]        r_req_pf;
    logic [10:0]       r_req_vf;
    logic              r_req_vf_active;
    logic [63:0]       r_req_wdata;

    logic              w_start;
    logic              w_accept;
    logic              w_req_state;
    logic              w_is_write;
    logic              w_use_p1;
    logic              w_waiting;
    csr_target_t       w_tgt;
    logic [63:0]       w_pattern;
    logic              w_resolved;
    logic              w_error;

    assign w_start     = start & (r_state == ST_IDLE);
    assign w_accept    = r_req_valid & req_ready;
    assign w_is_write  = (r_state == ST_WR0) | (r_state == ST_WR1);
    assign w_req_state = w_is_write | (r_state == ST_RD0) | (r_state == ST_RD1);
    assign w_use_p1    = (r_state == ST_WR1) | (r_state == ST_RD1) | (r_state == ST_WAIT1);
    assign w_waiting   = (r_state == ST_WAIT0) | (r_state == ST_WAIT1);
    assign w_tgt       = target_at(8'(r_idx));
    assign w_pattern   = w_use_p1 ? ~entry_pattern(PATTERN, 8'(r_idx))
                                  :  entry_pattern(PATTERN, 8'(r_idx));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: request phases advance on accept, waits on resolution.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start)      w_state_nxt = ST_WR0;
            ST_WR0:   if (w_accept)   w_state_nxt = ST_RD0;
            ST_RD0:   if (w_accept)   w_state_nxt = ST_WAIT0;
            ST_WAIT0: if (w_resolved) w_state_nxt = (w_error && r_stop_on_fail) ? ST_FIN : ST_WR1;
            ST_WR1:   if (w_accept)   w_state_nxt = ST_RD1;
            ST_RD1:   if (w_accept)   w_state_nxt = ST_WAIT1;
            ST_WAIT1: if (w_resolved) w_state_nxt = (w_error && r_stop_on_fail) ? ST_FIN : ST_NEXT;
            ST_NEXT:  w_state_nxt = (r_idx == C_IDX_LAST) ? ST_FIN : ST_WR0;
            ST_FIN:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Walk context: table index, stop policy latched at start, result flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx          <= '0;
            r_stop_on_fail <= 1'b0;
            r_pass         <= 1'b0;
        end else if (w_start) begin
            r_idx          <= '0;
            r_stop_on_fail <= stop_on_fail;
            r_pass         <= 1'b0;
        end else begin
            if ((r_state == ST_NEXT) && (r_idx != C_IDX_LAST)) begin
                r_idx <= r_idx + TIDX_W'(1);
            end
            if (r_state == ST_FIN) begin
                r_pass <= (err_count == '0);
            end
        end
    end

    // Request register: loaded one cycle after entering a request state and
    // held unchanged until the handshake completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_valid     <= 1'b0;
            r_req_write     <= 1'b0;
            r_req_addr      <= '0;
            r_req_pf        <= '0;
            r_req_vf        <= '0;
            r_req_vf_active <= 1'b0;
            r_req_wdata     <= '0;
        end else if (w_req_state && !r_req_valid) begin
            r_req_valid     <= 1'b1;
            r_req_write     <= w_is_write;
            r_req_addr      <= w_tgt.addr;
            r_req_pf        <= w_tgt.pf;
            r_req_vf        <= w_tgt.vf;
            r_req_vf_active <= w_tgt.vf_active;
            r_req_wdata     <= w_is_write ? w_pattern : 64'd0;
        end else if (w_accept) begin
            r_req_valid <= 1'b0;
        end
    end

    // Tag advances on every accepted request, posted writes included.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag <= '0;
        end else if (w_accept) begin
            r_tag <= r_tag + TAG_W'(1);
        end
    end

    csr_walk_rsp_checker #(
        .TAG_W          (TAG_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIDX_W         (TIDX_W)
    ) u_rsp_checker (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_start),
        .i_arm        (w_accept & ~r_req_write),
        .i_arm_tag    (r_tag),
        .i_arm_data   (w_pattern),
        .i_arm_idx    (r_idx),
        .i_waiting    (w_waiting),
        .i_rsp_valid  (rsp_valid),
        .i_rsp_tag    (rsp_tag),
        .i_rsp_data   (rsp_data),
        .o_resolved   (w_resolved),
        .o_error      (w_error),
        .o_err_count  (err_count),
        .o_fail_idx   (fail_idx),
        .o_fail_code  (fail_code),
        .o_fail_rdata (fail_rdata)
    );

    assign req_valid     = r_req_valid;
    assign req_write     = r_req_write;
    assign req_addr      = r_req_addr;
    assign req_pf        = r_req_pf;
    assign req_vf        = r_req_vf;
    assign req_vf_active = r_req_vf_active;
    assign req_wdata     = r_req_wdata;
    assign req_tag       = r_tag;
    assign busy          = (r_state != ST_IDLE) && (r_state != ST_FIN);
    assign done          = (r_state == ST_FIN);
    assign pass          = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_csr_scratch_walker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_csr_scratch_walker
// Brief    : Scoreboard bench for csr_scratch_walker with an echoing MMIO
//            responder and per-walk fault injection.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_scratch_walker;

    localparam int          NT  = 5;
    localparam logic [63:0] PAT = 64'hA5A5_5A5A_0F0F_F0F0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop_on_fail = 1'b0;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [7:0]  rsp_tag = 8'd0;
    logic [63:0] rsp_data = 64'd0;
    logic        req_valid, req_write, req_vf_active, busy, done, pass;
    logic [63:0] req_addr, req_wdata, fail_rdata;
    logic [2:0]  req_pf, fail_idx;
    logic [10:0] req_vf;
    logic [7:0]  req_tag;
    logic [3:0]  err_count;
    logic [1:0]  fail_code;

    always #5 clk = ~clk;

    csr_scratch_walker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop_on_fail(stop_on_fail),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_pf(req_pf), .req_vf(req_vf),
        .req_vf_active(req_vf_active), .req_wdata(req_wdata), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_idx(fail_idx), .fail_code(fail_code), .fail_rdata(fail_rdata)
    );

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [2:0]  pf;
        logic [63:0] wdata;
        int          idx;
        int          ph;
    } req_t;

    typedef struct {
        int          due;
        logic [7:0]  tag;
        logic [63:0] data;
    } rsp_t;

    logic [63:0] t_addr [NT] = '{64'h28, 64'h10008, 64'h20018, 64'h100, 64'h18};
    logic [2:0]  t_pf   [NT] = '{3'd0, 3'd0, 3'd3, 3'd2, 3'd1};

    req_t        exp_q[$];
    rsp_t        pend_q[$];
    logic [63:0] mem [logic [63:0]];

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_acc = 0;
    logic [7:0]  tag_model = 8'd0;

    // fault injection knobs
    int          bad_e, bad_ph, bad2_e, bad2_ph, drop_e, tagb_e, stall_e, stall_ph;
    logic [63:0] bad_data, bad2_data;
    int          stall_left, stall_seen, stall_bad;
    int          drop_acc_cyc, trig_cyc;
    logic [63:0] e0_wdata [2];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_faults();
        bad_e = -1; bad_ph = 0; bad2_e = -1; bad2_ph = 0; drop_e = -1; tagb_e = -1;
        stall_e = -1; stall_ph = 0; stall_left = 0; stall_seen = 0; stall_bad = 0;
        bad_data = 64'd0; bad2_data = 64'd0; drop_acc_cyc = -1; trig_cyc = -1;
    endtask

    function automatic bit fault_at(input int e, input int ph);
        return (e == bad_e && ph == bad_ph) || (e == bad2_e && ph == bad2_ph) ||
               (ph == 0 && (e == drop_e || e == tagb_e));
    endfunction

    // Expected request stream; with stop_on_fail the walk ends at the first faulty read.
    task automatic build_expect(input bit sof);
        req_t it;
        exp_q.delete();
        for (int e = 0; e < NT; e++) begin
            for (int ph = 0; ph < 2; ph++) begin
                it.addr  = t_addr[e];
                it.pf    = t_pf[e];
                it.idx   = e;
                it.ph    = ph;
                it.wr    = 1'b1;
                it.wdata = (ph == 0) ? PAT + 64'(e) : ~(PAT + 64'(e));
                exp_q.push_back(it);
                it.wr    = 1'b0;
                it.wdata = 64'd0;
                exp_q.push_back(it);
                if (sof && fault_at(e, ph)) return;
            end
        end
    endtask

    // One cycle: deliver due responses, choose req_ready, score an accept.
    task automatic tick();
        req_t it;
        rsp_t r;
        bit   stalling;
        @(negedge clk);
        cyc++;
        rsp_valid = 1'b0;
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            r = pend_q.pop_front();
            rsp_valid = 1'b1;
            rsp_tag   = r.tag;
            rsp_data  = r.data;
        end
        stalling = req_valid && stall_left > 0 && exp_q.size() > 0 &&
                   exp_q[0].wr && exp_q[0].idx == stall_e && exp_q[0].ph == stall_ph;
        req_ready = !stalling;
        if (stalling) begin
            stall_left--;
            stall_seen++;
            if (req_addr !== exp_q[0].addr || req_wdata !== exp_q[0].wdata ||
                req_tag !== tag_model || req_write !== 1'b1) stall_bad++;
        end
        if (req_valid && req_ready) begin
            n_acc++;
            check_eq("req_in_queue", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                check_eq("req_write", req_write, it.wr);
                check_eq("req_addr", req_addr, it.addr);
                check_eq("req_pf", req_pf, it.pf);
                check_eq("req_vf", {req_vf_active, req_vf}, 0);
                check_eq("req_tag", req_tag, tag_model);
                if (it.wr) begin
                    check_eq("req_wdata", req_wdata, it.wdata);
                    mem[req_addr] = req_wdata;
                    if (it.idx == 0) e0_wdata[it.ph] = req_wdata;
                end else begin
                    if (it.idx == drop_e && it.ph == 0) drop_acc_cyc = cyc;
                    if (it.idx == 3 && it.ph == 1) trig_cyc = cyc;
                    if (!(it.idx == drop_e && it.ph == 0)) begin
                        r.due  = cyc + 3;
                        r.tag  = (it.idx == tagb_e && it.ph == 0) ? req_tag + 8'd1 : req_tag;
                        r.data = mem.exists(req_addr) ? mem[req_addr] : 64'd0;
                        if (it.idx == bad_e && it.ph == bad_ph) r.data = bad_data;
                        if (it.idx == bad2_e && it.ph == bad2_ph) r.data = bad2_data;
                        pend_q.push_back(r);
                    end
                end
            end
            tag_model = tag_model + 8'd1;
        end
    endtask

    task automatic check_idle_zero(input string pfx);
        check_eq({pfx, "_req"}, {req_valid, req_write, req_vf_active, req_pf, req_vf}, 0);
        check_eq({pfx, "_req_addr"}, req_addr, 0);
        check_eq({pfx, "_req_wdata"}, req_wdata, 0);
        check_eq({pfx, "_req_tag"}, req_tag, 0);
        check_eq({pfx, "_status"}, {busy, done, pass, err_count, fail_idx, fail_code}, 0);
        check_eq({pfx, "_fail_rdata"}, fail_rdata, 0);
    endtask

    task automatic run_walk(input string name, input bit sof, input bit midstart,
                            input int e_err, input int e_idx, input int e_code,
                            input bit chk_rdata, input logic [63:0] e_rdata,
                            output int done_cyc);
        int  acc0, n_exp;
        bit  got_done;
        build_expect(sof);
        n_exp    = exp_q.size();
        acc0     = n_acc;
        got_done = 0;
        done_cyc = -1;
        stop_on_fail = sof;
        start = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            tick();
            start = midstart && (i == 12);
            if (i == 0) check_eq({name, "_busy_after_start"}, busy, 1);
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
                break;
            end
        end
        start = 1'b0;
        if (!got_done) check_eq({name, "_done_seen"}, done, 1);
        check_eq({name, "_err_count"}, err_count, 64'(e_err));
        check_eq({name, "_fail_idx"}, fail_idx, 64'(e_idx));
        check_eq({name, "_fail_code"}, fail_code, 64'(e_code));
        if (chk_rdata) check_eq({name, "_fail_rdata"}, fail_rdata, e_rdata);
        tick();
        check_eq({name, "_done_one_cycle"}, {done, busy}, 0);
        check_eq({name, "_pass"}, pass, 64'(e_err == 0));
        repeat (6) tick();
        check_eq({name, "_accept_count"}, 64'(n_acc - acc0), 64'(n_exp));
        check_eq({name, "_queue_empty"}, 64'(exp_q.size()), 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin : main
        int dc;
        int idle_bad;
        clear_faults();

        // reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check_idle_zero("reset");
        rst_n = 1'b1;
        tick();

        // ideal responder, with a stray start pulse mid-walk
        run_walk("ideal", 1'b0, 1'b1, 0, 0, 0, 1'b1, 64'd0, dc);
        check_eq("entry0_p0", e0_wdata[0], 64'hA5A55A5A0F0FF0F0);
        check_eq("entry0_p1", e0_wdata[1], 64'h5A5AA5A5F0F00F0F);

        // entry 2 first read returns zero, walk continues
        clear_faults();
        bad_e = 2; bad_ph = 0; bad_data = 64'd0;
        run_walk("e2_zero", 1'b0, 1'b0, 1, 2, 1, 1'b1, 64'd0, dc);

        // two data errors: only the first is captured
        clear_faults();
        bad_e = 1; bad_ph = 1; bad_data = 64'h1234_5678_9ABC_DEF0;
        bad2_e = 3; bad2_ph = 0; bad2_data = 64'hFFFF_0000_FFFF_0000;
        run_walk("two_err", 1'b0, 1'b0, 2, 1, 1, 1'b1, 64'h1234_5678_9ABC_DEF0, dc);

        // entry 1 never answers its first read, halt on failure
        clear_faults();
        drop_e = 1;
        run_walk("timeout", 1'b1, 1'b0, 1, 1, 2, 1'b1, 64'd0, dc);
        // accept edge follows tick drop_acc_cyc; timeout flags land 1024 edges
        // later, and FIN is first visible on the following tick
        check_eq("timeout_latency", 64'(dc - drop_acc_cyc), 64'd1025);

        // back-pressure on entry 2 inverted write, then a mis-tagged completion
        clear_faults();
        stall_e = 2; stall_ph = 1; stall_left = 50;
        tagb_e = 3;
        run_walk("stall_tag", 1'b0, 1'b0, 1, 3, 3, 1'b0, 64'd0, dc);
        check_eq("stall_cycles", 64'(stall_seen), 64'd50);
        check_eq("stall_hold_bad", 64'(stall_bad), 64'd0);

        // reset while waiting on entry 3 inverted readback
        clear_faults();
        build_expect(1'b0);
        stop_on_fail = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 2000 && trig_cyc < 0; i++) begin
            tick();
            start = 1'b0;
        end
        check_eq("rst_trigger_seen", 64'(trig_cyc >= 0), 64'd1);
        tick();
        rst_n = 1'b0;
        tick();
        check_idle_zero("midreset");
        rst_n = 1'b1;
        exp_q.delete();
        tag_model = 8'd0;
        idle_bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (busy || done || req_valid || err_count != 0 || fail_code != 0) idle_bad++;
        end
        check_eq("late_rsp_ignored", 64'(idle_bad), 64'd0);
        check_eq("late_rsp_queue", 64'(pend_q.size()), 64'd0);

        // clean walk after reset, tags restart from zero
        clear_faults();
        run_walk("post_reset", 1'b0, 1'b0, 0, 0, 0, 1'b1, 64'd0, dc);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
